// File: rtl/data_ram_responder_if.sv
// Load/store bus between the CPU memory stage (master) and the data RAM
// responder (slave).
interface data_ram_responder_if;
  logic        request;
  logic        write;
  logic [31:0] address;
  logic [3:0]  select;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        stall;

  modport master (
    output request, write, address, select, write_data,
    input  read_data, ready, stall
  );

  modport slave (
    input  request, write, address, select, write_data,
    output read_data, ready, stall
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data RAM on the CPU load/store port with LATENCY wait states and byte-lane
// stores; stalls the pipeline until the single-cycle ready pulse.
module data_ram_responder #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 2
) (
  input logic                 clock,
  input logic                 reset,
  data_ram_responder_if.slave bus
);

  localparam int WORDS = 2 ** ADDRESS_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               counter_q, counter_d;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] index_q;
  logic [3:0]               select_q;
  logic [31:0]              writeData_q;
  logic [31:0]              readData_q;
  logic [31:0]              mem [WORDS];

  logic                     accWrite;
  logic [ADDRESS_WIDTH-1:0] accIndex;
  logic [3:0]               accSelect;
  logic [31:0]              accData;
  logic                     enterRespond;
  logic                     unusedAddrBits;

  assign unusedAddrBits = ^{bus.address[31:ADDRESS_WIDTH+2], bus.address[1:0]};

  // With zero latency the commit edge is also the accepting edge, so the
  // access fields come straight from the bus while IDLE, else from the latch.
  assign accWrite  = (state_q == IDLE) ? bus.write : write_q;
  assign accIndex  = (state_q == IDLE) ? bus.address[ADDRESS_WIDTH+1:2] : index_q;
  assign accSelect = (state_q == IDLE) ? bus.select : select_q;
  assign accData   = (state_q == IDLE) ? bus.write_data : writeData_q;

  assign enterRespond = !reset && (state_d == RESPOND) && (state_q != RESPOND);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          if (LATENCY == 0) begin
            state_d = RESPOND;
          end else begin
            state_d   = WAIT;
            counter_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (counter_q != 4'd0) begin
          counter_d = counter_q - 4'd1;
        end else begin
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    if (state_q == RESPOND) begin
      bus.ready = 1'b1;
    end
  end

  assign bus.stall     = bus.request & ~bus.ready;
  assign bus.read_data = readData_q;

  always_ff @(posedge clock) begin
    if (state_q == IDLE && bus.request) begin
      write_q     <= bus.write;
      index_q     <= bus.address[ADDRESS_WIDTH+1:2];
      select_q    <= bus.select;
      writeData_q <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (enterRespond && accWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (accSelect[i]) begin
          mem[accIndex][8*i +: 8] <= accData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readData_q <= 32'd0;
    end else if (enterRespond && !accWrite) begin
      readData_q <= mem[accIndex];
    end
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Data-memory responder on the CPU's load/store port: the target side of the request the CPU memory stage initiates.
- Models a RAM with programmable wait states and byte-lane writes.
- Drives a stall back into the pipeline until each access completes.
- Sits in sopc beside the instruction ROM and replaces the zero-latency data RAM, so load-stall and memory-stall paths are exercised.

Parameters:
- ADDRESS_WIDTH, 10, log2 of word count; the array holds 2^ADDRESS_WIDTH 32-bit words.
- LATENCY, 2, wait cycles inserted before each response; legal range 0..15.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  1  CPU access request; held stable by the CPU until ready.
- write  input  1  1 = store, 0 = load; valid while request = 1.
- address  input  32  byte address; word index = address[ADDRESS_WIDTH+1:2]; bits [1:0] and upper bits ignored.
- select  input  4  byte-lane enables for stores; bit i covers data bits [8i+7:8i].
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- ready  output  1  one-cycle completion pulse.
- stall  output  1  combinational: request & ~ready; feeds the pipeline stall controller.

Behaviour:
- State machine: IDLE, WAIT, RESPOND.
- Reset: state = IDLE; counter = 0; ready = 0; read_data = 0. Memory contents are not cleared.
- IDLE:
  - request = 0 → stay in IDLE.
  - request = 1 and LATENCY = 0 → RESPOND.
  - request = 1 and LATENCY > 0 → WAIT, counter = LATENCY-1.
  - Latch write, address, select and write_data on the accepting edge; later input changes are ignored for this access.
- WAIT:
  - counter != 0 → decrement.
  - counter = 0 → RESPOND.
- Edge entering RESPOND:
  - Store: each lane with select[i] = 1 is written from the latched data. Unselected lanes are unchanged.
  - Load: read_data is loaded with the full word at the latched index. select is ignored for loads; the CPU extracts bytes and halfwords.
- RESPOND: ready = 1 for exactly this cycle; then → IDLE unconditionally.
- Request held high through RESPOND (CPU did not yet deassert) is treated as a new access, sampled again in the following IDLE cycle.
- Latency: request first high in cycle 0 → ready high in cycle LATENCY+1. stall is high in cycles 0..LATENCY and low in cycle LATENCY+1.
- ready = 0 in every state other than RESPOND.
- read_data holds its last value until the next load completes; stores do not change it.
- select = 0000 store: completes with normal timing and modifies nothing.
- Address wrap: index beyond the array aliases modulo 2^ADDRESS_WIDTH words.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the access; no write is committed; state → IDLE next edge.
  - Reset asserted in RESPOND: the write has already been committed at entry and stands; ready drops on the next edge.
- Reset has priority over every transition.
- Back-to-back accesses: minimum spacing is LATENCY+2 cycles between accepting edges, because IDLE is re-entered for one cycle.

Test Plan:
- LATENCY=2, store address 0x00000010, select 1111, write_data 0x00001234 → stall high 3 cycles, ready pulse in cycle 3; a following load of 0x10 returns read_data 0x00001234 with ready in cycle 3 of that access.
- Byte store over word 0x00001234 at 0x10, select 0001, write_data 0x000000AB → reload returns 0x000012AB. Then select 1000, write_data 0x89000000 → reload returns 0x890012AB.
- LATENCY=0, load 0x10 → ready in the cycle after request; stall high for exactly 1 cycle; read_data correct.
- Reset asserted during second WAIT cycle of a store of 0xFFFFFFFF to 0x20 (previous value 0x00000000) → ready never pulses; reload of 0x20 returns 0x00000000; read_data = 0 immediately after reset.
- Request held high across two accesses (store 0x000089AB to 0x04, then load 0x04 with write switched in IDLE) → two distinct ready pulses LATENCY+2 cycles apart; second returns 0x000089AB.
- ADDRESS_WIDTH=10, store 0x00001234 to address 0x00001010 → load of 0x00000010 returns 0x00001234 (alias).
